// File: rtl/keypad_arbiter.sv
// Round-robin arbiter sharing the security core's command/digit port between NUM_PADS keypads.
// Optional lockout after repeated digit timeouts: define KEYPAD_ARBITER_LOCKOUT_EN.
module keypad_arbiter #(
  parameter int         NUM_PADS    = 2,
  parameter int         PIN_LEN     = 3,
  parameter int         TIMEOUT     = 1000,
  parameter int         SETTLE      = 2,
  parameter logic [3:0] FILL_DIGIT  = 4'hF,
  parameter int         LOCK_FAILS  = 3,
  parameter int         LOCK_CYCLES = 5000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2*NUM_PADS-1:0] pad_command,
  input  logic [4*NUM_PADS-1:0] pad_digit,
  input  logic [NUM_PADS-1:0]   pad_digit_entered,
  output logic [1:0]            command,
  output logic [3:0]            digit,
  output logic                  digit_enterd,
  output logic [NUM_PADS-1:0]   grant,
  output logic                  busy,
  output logic                  timeout,
  output logic                  locked
);

  localparam int PW = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(PIN_LEN + 1);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_COLLECT, S_FLUSH, S_SETTLE} state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       rr_ptr, rr_ptr_d;
  logic [PW-1:0]       owner, owner_d;
  logic [NUM_PADS-1:0] grant_d;
  logic                busy_d, digit_enterd_d, timeout_d;
  logic [1:0]          command_d;
  logic [3:0]          digit_d;
  logic [CW-1:0]       cnt, cnt_d;
  logic [TW-1:0]       timer, timer_d;

  logic [NUM_PADS-1:0] req;
  logic [PW-1:0]       cand, win_idx;
  logic                win_vld;
  logic                own_stb;
  logic [3:0]          own_dig;
  logic                lock_active;

  // Only commands 1 (arm) and 2 (disarm) request a session.
  always_comb begin
    req     = '0;
    cand    = '0;
    win_idx = '0;
    win_vld = 1'b0;
    for (int i = 0; i < NUM_PADS; i++) begin
      req[i] = (pad_command[2*i +: 2] == 2'd1) || (pad_command[2*i +: 2] == 2'd2);
    end
    // Descending scan so the requester closest to rr_ptr is assigned last and wins.
    for (int k = NUM_PADS - 1; k >= 0; k--) begin
      cand = PW'((int'(rr_ptr) + k) % NUM_PADS);
      if (req[cand]) begin
        win_idx = cand;
        win_vld = 1'b1;
      end
    end
  end

  assign own_stb = pad_digit_entered[owner];
  assign own_dig = pad_digit[4*owner +: 4];

`ifdef KEYPAD_ARBITER_LOCKOUT_EN
  localparam int FW  = $clog2(LOCK_FAILS + 1);
  localparam int LTW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  logic [FW-1:0]  fail_cnt, fail_d;
  logic [LTW-1:0] lock_timer, lock_timer_d;
  logic           locked_q, locked_d;
  assign lock_active = locked_q;
  assign locked      = locked_q;
`else
  assign lock_active = 1'b0;
  assign locked      = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr;
    owner_d        = owner;
    grant_d        = grant;
    busy_d         = busy;
    command_d      = 2'd0;
    digit_d        = 4'd0;
    digit_enterd_d = 1'b0;
    timeout_d      = 1'b0;
    cnt_d          = cnt;
    timer_d        = timer;
`ifdef KEYPAD_ARBITER_LOCKOUT_EN
    fail_d       = fail_cnt;
    lock_timer_d = lock_timer;
    locked_d     = locked_q;
    if (locked_q) begin
      if (lock_timer == LTW'(LOCK_CYCLES - 1)) begin
        locked_d     = 1'b0;
        lock_timer_d = '0;
        fail_d       = '0;
      end else begin
        lock_timer_d = lock_timer + 1'b1;
      end
    end
`endif
    case (state_q)
      S_IDLE: begin
        if (win_vld && !lock_active) begin
          state_d   = S_CMD;
          owner_d   = win_idx;
          grant_d   = NUM_PADS'(1) << win_idx;
          busy_d    = 1'b1;
          command_d = pad_command[2*win_idx +: 2];
          rr_ptr_d  = (win_idx == PW'(NUM_PADS - 1)) ? '0 : win_idx + 1'b1;
        end
      end
      S_CMD: begin
        // Strobes arriving alongside the command are intentionally dropped.
        state_d = S_COLLECT;
        cnt_d   = '0;
        timer_d = '0;
      end
      S_COLLECT: begin
        if (own_stb) begin
          digit_enterd_d = 1'b1;
          digit_d        = own_dig;
          cnt_d          = cnt + 1'b1;
          timer_d        = '0;
          if (cnt == CW'(PIN_LEN - 1)) begin
            state_d = S_SETTLE;
`ifdef KEYPAD_ARBITER_LOCKOUT_EN
            fail_d = '0;
`endif
          end
        end else begin
          timer_d = (timer == TW'(TIMEOUT)) ? timer : timer + 1'b1;
          if (timer >= TW'(TIMEOUT - 1)) begin
            timeout_d = 1'b1;
            state_d   = S_FLUSH;
`ifdef KEYPAD_ARBITER_LOCKOUT_EN
            fail_d = fail_cnt + 1'b1;
            if (fail_cnt == FW'(LOCK_FAILS - 1)) begin
              locked_d     = 1'b1;
              lock_timer_d = '0;
            end
`endif
          end
        end
      end
      S_FLUSH: begin
        // Filler digits make the core's PIN compare fail so it returns to its idle path.
        digit_enterd_d = 1'b1;
        digit_d        = FILL_DIGIT;
        cnt_d          = cnt + 1'b1;
        if (cnt == CW'(PIN_LEN - 1)) begin
          state_d = S_SETTLE;
          timer_d = '0;
        end
      end
      S_SETTLE: begin
        if (timer == TW'(SETTLE - 1)) begin
          state_d = S_IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          timer_d = '0;
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      grant        <= '0;
      busy         <= 1'b0;
      command      <= 2'd0;
      digit        <= 4'd0;
      digit_enterd <= 1'b0;
      timeout      <= 1'b0;
      cnt          <= '0;
      timer        <= '0;
`ifdef KEYPAD_ARBITER_LOCKOUT_EN
      fail_cnt     <= '0;
      lock_timer   <= '0;
      locked_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rr_ptr       <= rr_ptr_d;
      owner        <= owner_d;
      grant        <= grant_d;
      busy         <= busy_d;
      command      <= command_d;
      digit        <= digit_d;
      digit_enterd <= digit_enterd_d;
      timeout      <= timeout_d;
      cnt          <= cnt_d;
      timer        <= timer_d;
`ifdef KEYPAD_ARBITER_LOCKOUT_EN
      fail_cnt     <= fail_d;
      lock_timer   <= lock_timer_d;
      locked_q     <= locked_d;
`endif
    end
  end

endmodule
